// File: rtl/control_fsm.sv
// Multicycle controller for the 16-bit CR16-style CPU: decodes IR and PSR flags into datapath controls.
// Optional WAIT/HALT support is enabled by defining CONTROL_FSM_HALT_EN.
module control_fsm #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] instr,
    input  logic [1:0]      flags1,
    input  logic [2:0]      flags2,
    output logic            MemW1en,
    output logic            MemW2en,
    output logic            RFen,
    output logic            PSRen,
    output logic            PCen,
    output logic            INSTRen,
    output logic            Movm,
    output logic            A1m,
    output logic [1:0]      PCm,
    output logic [1:0]      A2m,
    output logic [1:0]      RWm,
    output logic [3:0]      aluOp
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FETCH2,
        S_DECODE,
        S_EXEC,
        S_LOAD_RD,
        S_LOAD_WB,
        S_HALT
    } state_t;

    state_t state_reg, state_next;

    logic [3:0] op, ext, cond, alu_code;
    logic       c_flag, f_flag, l_flag, n_flag, z_flag;
    logic       cond_true, is_imm, alu_valid;
    logic       unused_bits;

    assign op     = instr[15:12];
    assign cond   = instr[11:8];
    assign ext    = instr[7:4];
    assign c_flag = flags1[1];
    assign f_flag = flags1[0];
    assign l_flag = flags2[2];
    assign n_flag = flags2[1];
    assign z_flag = flags2[0];
    assign unused_bits = ^instr[3:0];

    assign MemW1en = 1'b0;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'h0: cond_true = z_flag;
            4'h1: cond_true = !z_flag;
            4'h2: cond_true = c_flag;
            4'h3: cond_true = !c_flag;
            4'h4: cond_true = l_flag;
            4'h5: cond_true = !l_flag;
            4'h6: cond_true = n_flag;
            4'h7: cond_true = !n_flag;
            4'h8: cond_true = f_flag;
            4'h9: cond_true = !f_flag;
            4'hA: cond_true = !l_flag && !z_flag;
            4'hB: cond_true = l_flag || z_flag;
            4'hC: cond_true = !n_flag && !z_flag;
            4'hD: cond_true = n_flag || z_flag;
            4'hE: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Register-register ALU ops use the ext field; the immediate forms reuse the same code as op.
    always_comb begin
        is_imm    = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
        alu_code  = (op == 4'h0) ? ext : op;
        alu_valid = is_imm ||
                    ((op == 4'h0) && (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        MemW2en    = 1'b0;
        RFen       = 1'b0;
        PSRen      = 1'b0;
        PCen       = 1'b0;
        INSTRen    = 1'b0;
        Movm       = 1'b0;
        A1m        = 1'b0;
        PCm        = 2'd0;
        A2m        = 2'd0;
        RWm        = 2'd0;
        aluOp      = 4'd0;

        case (state_reg)
            S_FETCH: state_next = S_FETCH2;
            S_FETCH2: begin
                INSTRen    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (op == 4'h4 && ext == 4'h0) begin
                    state_next = S_LOAD_RD;
`ifdef CONTROL_FSM_HALT_EN
                end else if (instr == '0) begin
                    state_next = S_HALT;
`endif
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_LOAD_RD: state_next = S_LOAD_WB;
            S_LOAD_WB: begin
                RWm        = 2'd0;
                RFen       = 1'b1;
                PCen       = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC: begin
                // Every executed instruction commits its PC update here; undefined ones are NOPs.
                PCen       = 1'b1;
                state_next = S_FETCH;
                if (alu_valid) begin
                    Movm = 1'b1;
                    RWm  = 2'd2;
                    A2m  = (op == 4'h0) ? 2'd0 : 2'd2;
                    case (alu_code)
                        4'h5: begin aluOp = 4'd3; RFen = 1'b1; PSRen = 1'b1; end
                        4'h9: begin aluOp = 4'd4; RFen = 1'b1; PSRen = 1'b1; end
                        4'hB: begin aluOp = 4'd5; PSRen = 1'b1; end
                        4'h1: begin aluOp = 4'd0; RFen = 1'b1; end
                        4'h2: begin aluOp = 4'd1; RFen = 1'b1; end
                        4'h3: begin aluOp = 4'd2; RFen = 1'b1; end
                        4'hD: begin Movm = 1'b0; RFen = 1'b1; end
                        default: ;
                    endcase
                end else begin
                    case (op)
                        4'h8: begin
                            if (ext == 4'h4 || ext == 4'h0 || ext == 4'h1) begin
                                Movm  = 1'b1;
                                RWm   = 2'd2;
                                aluOp = 4'd6;
                                RFen  = 1'b1;
                                A2m   = (ext == 4'h4) ? 2'd0 : 2'd1;
                            end
                        end
                        4'hF: begin
                            RWm  = 2'd3;
                            RFen = 1'b1;
                        end
                        4'h4: begin
                            case (ext)
                                4'h4: MemW2en = 1'b1;
                                4'h8: begin
                                    RWm  = 2'd1;
                                    RFen = 1'b1;
                                    PCm  = 2'd1;
                                end
                                4'hC: PCm = cond_true ? 2'd1 : 2'd0;
                                default: ;
                            endcase
                        end
                        4'hC: begin
                            A1m   = 1'b1;
                            A2m   = 2'd2;
                            aluOp = 4'd3;
                            PCm   = cond_true ? 2'd2 : 2'd0;
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase

        // Reset may land mid-instruction; suppress every write so no partial commit occurs.
        if (reset) begin
            MemW2en = 1'b0;
            RFen    = 1'b0;
            PSRen   = 1'b0;
            PCen    = 1'b0;
            INSTRen = 1'b0;
        end
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle controller FSM for the 16-bit CR16-style processor. It decodes the instruction register and PSR flags produced by `datapath` and drives every datapath enable, mux select and ALU opcode. It sits beside `datapath` at the CPU top level and replaces the temporary test FSM.

## Interface
- `SIZE`, 16, instruction width.
- `clk` input 1: system clock.
- `reset` input 1: reset. One clock; reset is synchronous and active-high.
- `instr` input 16: instruction register contents.
- `flags1` input 2: PSR group 1, `{C, F}`.
- `flags2` input 3: PSR group 2, `{L, N, Z}`.
- `MemW1en`, `MemW2en`, `RFen`, `PSRen`, `PCen`, `INSTRen` output 1 each: write enables.
- `Movm`, `A1m` output 1 each: mux selects.
  - `Movm`: 0 = A2 mux, 1 = ALU.
  - `A1m`: 0 = `RFread1`, 1 = PC.
- `PCm` output 2: 0 = PC+1, 1 = `RFread2`, 2 = ALU.
- `A2m` output 2: 0 = `RFread2`, 1 = `instr[3:0]` zero-extended, 2 = sign-extended imm8.
- `RWm` output 2: 0 = `MemRead2`, 1 = PC+1, 2 = Mov mux, 3 = imm8<<8.
- `aluOp` output 4: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 CMP, 6 LSH.

## Operation
- **Output style:** Moore outputs, decoded from the registered state and `instr`.
- **Default outputs:** every enable is 0, every select is 0, and `aluOp` is 0, unless a state states otherwise.
- **States:** FETCH → FETCH2 → DECODE → one of EXEC, LOAD_RD, HALT.
  - LOAD_RD → LOAD_WB.
  - EXEC and LOAD_WB → FETCH.
- **FETCH:** PC is on port A. No enables asserted (BRAM read latency 1).
- **FETCH2:** `INSTRen`=1.
- **DECODE:** no enables. Selects the next state.
- **Instruction fields:** `op` = `instr[15:12]`, `ext` = `instr[7:4]`, `cond` = `instr[11:8]`.
- **EXEC, R-type (`op`=0) and immediate forms (`op`=`ext` code, `A2m`=2):**
  - Common settings: `Movm`=1, `RWm`=2, `PCen`=1, `PCm`=0.
  - ADD 5 / SUB 9: `aluOp` 3/4, `RFen`=1, `PSRen`=1.
  - CMP B: `aluOp`=5, `PSRen`=1, `RFen`=0.
  - AND 1 / OR 2 / XOR 3: `aluOp` 0/1/2, `RFen`=1, PSR untouched.
  - MOV D: `Movm`=0, `RFen`=1.
  - LSH (`op`=8, `ext`=4): `aluOp`=6, `RFen`=1. LSHI (`ext`=0 or 1) uses `A2m`=1.
- **LUI (`op`=F):** `RWm`=3, `RFen`=1, PC+1.
- **Special group, `op`=4:**
  - LOAD (`ext`=0): DECODE→LOAD_RD (no enables) → LOAD_WB (`RWm`=0, `RFen`=1, `PCen`=1).
  - STOR (`ext`=4): EXEC with `MemW2en`=1, PC+1.
  - JAL (`ext`=8): EXEC with `RWm`=1, `RFen`=1, `PCm`=1, `PCen`=1.
  - Jcond (`ext`=C): `PCm`=1 if condition true, else 0. `PCen`=1.
- **Bcond (`op`=C):** `A1m`=1, `A2m`=2, `aluOp`=3. `PCm`=2 if condition true, else 0. `PCen`=1. Target = current PC + sext(imm8).
- **Conditions (`cond`):**
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 HI L; 5 LS !L; 6 GT N; 7 LE !N.
  - 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z.
  - C LT !N&!Z; D GE N|Z; E UC 1; F never.
- **Undefined encodings:** behave as NOP, i.e. EXEC with only `PCen`=1, `PCm`=0.
- `MemW1en` is always 0.

## Timing
- **Reset:** state=FETCH on the edge after `reset` is sampled high. While `reset` is high, all enables are forced to 0 regardless of state. This covers reset mid-instruction: no partial RF, PSR, PC or memory write occurs.
- **Latency:** 4 cycles per instruction; LOAD takes 5.
- **Commit point:** exactly one `PCen` pulse per instruction, in its final state.
- **Same-cycle writes:** JAL writes the link register and PC in the same cycle. The RF write uses pre-update PC+1.
- **Flag timing:** a flag change from a CMP is visible to the immediately following Bcond. The PSR updates at the end of the CMP EXEC, before that Bcond's DECODE.

## Configuration
- `CONTROL_FSM_HALT_EN`:
  - Defined: WAIT (`instr`=0x0000) moves DECODE→HALT. HALT holds all enables at 0 until reset.
  - Undefined: 0x0000 is a NOP.

## Test plan
- **ADD:** reset, then `instr`=0x0152 (ADD R1,R2) → cycle 4 shows `aluOp`=3, `A1m`=0, `A2m`=0, `Movm`=1, `RWm`=2, `RFen`=`PSRen`=`PCen`=1, `PCm`=0. Next state is FETCH.
- **Bcond:** `instr`=0xC0FE (BEQ −2) → EXEC shows `A1m`=1, `A2m`=2, `aluOp`=3.
  - `flags2`=001: `PCm`=2.
  - `flags2`=000: `PCm`=0, `PCen`=1.
- **LOAD:** `instr`=0x4305 (LOAD R3,[R5]) → LOAD_RD shows all enables 0. LOAD_WB shows `RWm`=0, `RFen`=1, `PCen`=1. Total 5 cycles.
- **LUI and JAL:**
  - `instr`=0xF412 (LUI R4,0x12) → `RWm`=3, `RFen`=1.
  - `instr`=0x4086 (JAL) → `RWm`=1, `PCm`=1, `RFen`=`PCen`=1.
- **Reset mid-instruction:** assert `reset` during LOAD_WB → every enable is 0 that cycle, and the FSM is in FETCH on the next cycle.
- **WAIT:**
  - With `CONTROL_FSM_HALT_EN` defined: `instr`=0x0000 → HALT, with `PCen` held 0 for 20 cycles.
  - Undefined: same stimulus gives a NOP, with one `PCen` pulse per 4 cycles.
